// File: rtl/ex_flags_stage.sv
// Execute-stage output register with a {Z,V,N} flag register and branch resolution.
// One register stage carries the ALU result to the next pipeline stage.
// The flag register updates only on accepted, flag-setting opcodes.
// A combinational branch decision is made against the flags.
// Optional feature, selected by the macro EX_FLAG_FWD_EN:
//   defined   - a branch checked in the same cycle as an accepted flag-setting op sees the new flags
//   undefined - branches see only the registered flags; upstream stalls on the flag hazard
module ex_flags_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [3:0]  aluop,
  input  logic [15:0] aluout,
  input  logic        err,
  input  logic [3:0]  dst_reg,
  input  logic        wr_en,
  input  logic        stall,
  input  logic        flush,
  input  logic        br_chk,
  input  logic [2:0]  br_cond,
  output logic        out_valid,
  output logic [15:0] out_result,
  output logic [3:0]  out_dst_reg,
  output logic        out_wr_en,
  output logic [2:0]  flags,
  output logic        br_taken
);

  // ALU opcodes
  localparam logic [3:0] OpAdd    = 4'd0;
  localparam logic [3:0] OpSub    = 4'd1;
  localparam logic [3:0] OpXor    = 4'd2;
  localparam logic [3:0] OpRed    = 4'd3;
  localparam logic [3:0] OpSll    = 4'd4;
  localparam logic [3:0] OpSra    = 4'd5;
  localparam logic [3:0] OpRor    = 4'd6;
  localparam logic [3:0] OpPaddsb = 4'd7;
  localparam logic [3:0] OpLlb    = 4'd8;
  localparam logic [3:0] OpLhb    = 4'd9;

  // Bit positions inside the flag register {Z,V,N}
  localparam int unsigned FlagZ = 2;
  localparam int unsigned FlagV = 1;
  localparam int unsigned FlagN = 0;

  // Update masks, one bit per flag
  localparam logic [2:0] MaskAll  = 3'b111;
  localparam logic [2:0] MaskZ    = 3'b100;
  localparam logic [2:0] MaskNone = 3'b000;

  // Branch condition codes
  localparam logic [2:0] CondNe  = 3'b000;
  localparam logic [2:0] CondEq  = 3'b001;
  localparam logic [2:0] CondGt  = 3'b010;
  localparam logic [2:0] CondLt  = 3'b011;
  localparam logic [2:0] CondGe  = 3'b100;
  localparam logic [2:0] CondLe  = 3'b101;
  localparam logic [2:0] CondOv  = 3'b110;
  localparam logic [2:0] CondAlw = 3'b111;

  logic        accept;
  logic        advance;
  logic [2:0]  upd_mask;
  logic [2:0]  calc_flags;
  logic [2:0]  new_flags;
  logic [2:0]  flags_d;
  logic [2:0]  eff_flags;
  logic        cond_true;

  logic        valid_q;
  logic [15:0] result_q;
  logic [3:0]  dst_q;
  logic        wr_en_q;
  logic [2:0]  flags_q;

  // Stage control: flush overrides stall, so a flushed cycle always advances
  always_comb begin
    advance = ~stall | flush;
    accept  = in_valid & ~stall & ~flush;
  end

  // Decode which flags the opcode is allowed to write
  always_comb begin
    upd_mask = MaskNone;
    case (aluop)
      OpAdd, OpSub:               upd_mask = MaskAll;
      OpXor, OpSll, OpSra, OpRor: upd_mask = MaskZ;
      OpRed, OpPaddsb, OpLlb,
      OpLhb:                      upd_mask = MaskNone;
      default:                    upd_mask = MaskNone;
    endcase
  end

  // Raw flags from the current ALU result, merged with the held bits by mask
  always_comb begin
    calc_flags        = 3'b000;
    calc_flags[FlagZ] = (aluout == 16'h0000);
    calc_flags[FlagV] = err;
    calc_flags[FlagN] = aluout[15];
    new_flags         = (flags_q & ~upd_mask) | (calc_flags & upd_mask);
    flags_d           = accept ? new_flags : flags_q;
  end

  // Flags seen by the branch evaluator
  always_comb begin
`ifdef EX_FLAG_FWD_EN
    eff_flags = flags_d;
`else
    eff_flags = flags_q;
`endif
  end

  // Branch condition evaluation against the effective flags
  always_comb begin
    cond_true = 1'b0;
    case (br_cond)
      CondNe:  cond_true = ~eff_flags[FlagZ];
      CondEq:  cond_true = eff_flags[FlagZ];
      CondGt:  cond_true = ~eff_flags[FlagZ] & ~eff_flags[FlagN];
      CondLt:  cond_true = eff_flags[FlagN];
      CondGe:  cond_true = eff_flags[FlagZ] | (~eff_flags[FlagZ] & ~eff_flags[FlagN]);
      CondLe:  cond_true = eff_flags[FlagZ] | eff_flags[FlagN];
      CondOv:  cond_true = eff_flags[FlagV];
      CondAlw: cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
    br_taken = br_chk & ~rst & cond_true;
  end

  // Valid and write-enable: loaded on accept, cleared on any other advancing edge
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      wr_en_q <= 1'b0;
    end else if (advance) begin
      valid_q <= accept;
      wr_en_q <= accept & wr_en;
    end
  end

  // Result and destination: loaded only on accept, otherwise held
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= 16'h0000;
      dst_q    <= 4'h0;
    end else if (accept) begin
      result_q <= aluout;
      dst_q    <= dst_reg;
    end
  end

  // Flag register: flags_d already folds in accept and the update mask
  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q <= 3'b000;
    end else begin
      flags_q <= flags_d;
    end
  end

  // Drive registered outputs
  always_comb begin
    out_valid   = valid_q;
    out_result  = result_q;
    out_dst_reg = dst_q;
    out_wr_en   = wr_en_q;
    flags       = flags_q;
  end

endmodule

// File: tb/tb_ex_flags_stage.sv
// Directed bench for ex_flags_stage: reset, flag rules, stall/flush, branch conditions.
module tb_ex_flags_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [3:0]  aluop;
  logic [15:0] aluout;
  logic        err;
  logic [3:0]  dst_reg;
  logic        wr_en;
  logic        stall;
  logic        flush;
  logic        br_chk;
  logic [2:0]  br_cond;
  logic        out_valid;
  logic [15:0] out_result;
  logic [3:0]  out_dst_reg;
  logic        out_wr_en;
  logic [2:0]  flags;
  logic        br_taken;

  int checks   = 0;
  int failures = 0;

  ex_flags_stage dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .aluop       (aluop),
    .aluout      (aluout),
    .err         (err),
    .dst_reg     (dst_reg),
    .wr_en       (wr_en),
    .stall       (stall),
    .flush       (flush),
    .br_chk      (br_chk),
    .br_cond     (br_cond),
    .out_valid   (out_valid),
    .out_result  (out_result),
    .out_dst_reg (out_dst_reg),
    .out_wr_en   (out_wr_en),
    .flags       (flags),
    .br_taken    (br_taken)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle away from it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [15:0] res,
                       input logic e, input logic [3:0] dst, input logic we);
    in_valid = v;
    aluop    = op;
    aluout   = res;
    err      = e;
    dst_reg  = dst;
    wr_en    = we;
  endtask

  task automatic br(input logic [2:0] cond, input logic exp, input string tag);
    br_chk  = 1'b1;
    br_cond = cond;
    #1;
    chk(tag, {15'd0, br_taken}, {15'd0, exp});
  endtask

  initial begin
    rst = 1'b1; stall = 1'b1; flush = 1'b0; br_chk = 1'b1; br_cond = 3'b111;
    drive(1'b1, 4'd0, 16'hBEEF, 1'b1, 4'hA, 1'b1);
    #1;
    chk("br_during_rst", {15'd0, br_taken}, 16'd0);
    step();
    stall = 1'b0; flush = 1'b1;
    step();
    chk("rst_valid", {15'd0, out_valid}, 16'd0);
    chk("rst_result", out_result, 16'h0000);
    chk("rst_dst", {12'd0, out_dst_reg}, 16'd0);
    chk("rst_wr_en", {15'd0, out_wr_en}, 16'd0);
    chk("rst_flags", {13'd0, flags}, 16'd0);

    rst = 1'b0; flush = 1'b0;
    drive(1'b0, 4'd0, 16'h0000, 1'b0, 4'h0, 1'b0);
    br(3'b000, 1'b1, "br_ne_reset");
    br(3'b001, 1'b0, "br_eq_reset");
    br(3'b010, 1'b1, "br_gt_reset");
    br(3'b011, 1'b0, "br_lt_reset");
    br_chk = 1'b0;
    br(3'b111, 1'b1, "br_always");
    br_chk = 1'b0; #1;
    chk("br_chk_low", {15'd0, br_taken}, 16'd0);

    // ADD with overflow
    drive(1'b1, 4'd0, 16'h7FFF, 1'b1, 4'h1, 1'b1);
    step();
    chk("add_flags", {13'd0, flags}, 16'h0002);
    chk("add_result", out_result, 16'h7FFF);
    chk("add_valid", {15'd0, out_valid}, 16'd1);
    chk("add_dst", {12'd0, out_dst_reg}, 16'h0001);
    chk("add_wr_en", {15'd0, out_wr_en}, 16'd1);
    in_valid = 1'b0;
    br(3'b110, 1'b1, "br_ov");

    // SUB negative, then XOR zero keeps V and N
    br_chk = 1'b0;
    drive(1'b1, 4'd1, 16'hFFF0, 1'b0, 4'h2, 1'b0);
    step();
    chk("sub_flags", {13'd0, flags}, 16'h0001);
    chk("sub_wr_en", {15'd0, out_wr_en}, 16'd0);
    in_valid = 1'b0;
    br(3'b011, 1'b1, "br_lt_neg");
    br(3'b101, 1'b1, "br_le_neg");
    br(3'b100, 1'b0, "br_ge_neg");
    br_chk = 1'b0;
    drive(1'b1, 4'd2, 16'h0000, 1'b1, 4'h3, 1'b1);
    step();
    chk("xor_flags", {13'd0, flags}, 16'h0005);
    chk("xor_result", out_result, 16'h0000);
    in_valid = 1'b0;
    br(3'b001, 1'b1, "br_eq_zero");
    br(3'b000, 1'b0, "br_ne_zero");
    br_chk = 1'b0;

    // Stall three cycles with new inputs pending
    stall = 1'b1;
    drive(1'b1, 4'd0, 16'h1234, 1'b0, 4'h9, 1'b0);
    step(); step(); step();
    chk("stall_valid", {15'd0, out_valid}, 16'd1);
    chk("stall_result", out_result, 16'h0000);
    chk("stall_dst", {12'd0, out_dst_reg}, 16'h0003);
    chk("stall_wr_en", {15'd0, out_wr_en}, 16'd1);
    chk("stall_flags", {13'd0, flags}, 16'h0005);

    // Stall and flush together: flush wins
    flush = 1'b1;
    step();
    chk("sf_valid", {15'd0, out_valid}, 16'd0);
    chk("sf_wr_en", {15'd0, out_wr_en}, 16'd0);
    chk("sf_result", out_result, 16'h0000);
    chk("sf_flags", {13'd0, flags}, 16'h0005);
    stall = 1'b0; flush = 1'b0;

    // Clear flags, then non-flag ops leave them alone
    drive(1'b1, 4'd0, 16'h0005, 1'b0, 4'h4, 1'b1);
    step();
    chk("add5_flags", {13'd0, flags}, 16'h0000);
    drive(1'b1, 4'd8, 16'h0000, 1'b1, 4'h5, 1'b1);
    step();
    chk("llb_flags", {13'd0, flags}, 16'h0000);
    chk("llb_result", out_result, 16'h0000);
    chk("llb_dst", {12'd0, out_dst_reg}, 16'h0005);
    drive(1'b1, 4'd12, 16'h8000, 1'b1, 4'h6, 1'b1);
    step();
    chk("op12_flags", {13'd0, flags}, 16'h0000);
    chk("op12_result", out_result, 16'h8000);

    // Invalid cycle: nothing loads
    drive(1'b0, 4'd0, 16'h0000, 1'b1, 4'h7, 1'b1);
    step();
    chk("inv_valid", {15'd0, out_valid}, 16'd0);
    chk("inv_result", out_result, 16'h8000);
    chk("inv_dst", {12'd0, out_dst_reg}, 16'h0006);
    chk("inv_flags", {13'd0, flags}, 16'h0000);

    // Same-cycle branch on a flag-setting accept
    drive(1'b1, 4'd1, 16'h0000, 1'b0, 4'h8, 1'b1);
`ifdef EX_FLAG_FWD_EN
    br(3'b001, 1'b1, "br_same_cycle");
`else
    br(3'b001, 1'b0, "br_same_cycle");
`endif
    step();
    chk("sub0_flags", {13'd0, flags}, 16'h0004);
    in_valid = 1'b0;
    br(3'b001, 1'b1, "br_eq_after");
    br_chk = 1'b0;

    // Reset during a stall discards the held instruction
    drive(1'b1, 4'd0, 16'h7777, 1'b0, 4'hB, 1'b1);
    stall = 1'b1;
    step();
    rst = 1'b1;
    br_chk = 1'b1; br_cond = 3'b111; #1;
    chk("br_rst_mid", {15'd0, br_taken}, 16'd0);
    step();
    chk("rst2_valid", {15'd0, out_valid}, 16'd0);
    chk("rst2_result", out_result, 16'h0000);
    chk("rst2_flags", {13'd0, flags}, 16'h0000);

    // First accept right after reset release
    rst = 1'b0; stall = 1'b0; br_chk = 1'b0;
    drive(1'b1, 4'd0, 16'h0001, 1'b0, 4'h2, 1'b1);
    step();
    chk("post_rst_valid", {15'd0, out_valid}, 16'd1);
    chk("post_rst_result", out_result, 16'h0001);
    chk("post_rst_dst", {12'd0, out_dst_reg}, 16'h0002);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
